// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with stall, flush and a saturating held-cycle counter.
// Define PIPE_STAGE_REG_SKID_EN for a two-entry skid buffer with a registered ready_o.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data0_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [15:0]       stall_cnt_o
);
  localparam int ENT_W = 2*DATA_W + ADDR_W + CTRL_W;
  logic [ENT_W-1:0] in_ent, out_q;
  logic [15:0] cnt_q, cnt_d;
  logic vld, acc, tk;
  assign in_ent = {data0_i, data1_i, rd_addr_i, ctrl_i};
  assign acc = vld && ready_i && !stall_i;
  assign tk = valid_i && ready_o;
  assign valid_o = vld;
  assign {data0_o, data1_o, rd_addr_o} = out_q[ENT_W-1:CTRL_W];
  // bubbles must never present a stale RegWrite downstream
  assign ctrl_o = vld ? out_q[CTRL_W-1:0] : '0;
  assign stall_cnt_o = cnt_q;
`ifdef PIPE_STAGE_REG_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q;
  logic [ENT_W-1:0] skid_q;
  logic ready_q;
  assign vld = state_q != EMPTY;
  assign ready_o = ready_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      out_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else
      case (state_q)
        EMPTY: if (tk) begin
          state_q <= ONE;
          out_q <= in_ent;
        end
        ONE: if (tk && !acc) begin
          state_q <= TWO;
          skid_q <= in_ent;
          ready_q <= 1'b0;
        end else if (acc && !tk) state_q <= EMPTY;
        else if (tk) out_q <= in_ent;
        TWO: if (acc) begin
          state_q <= ONE;
          out_q <= skid_q;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
`else
  logic valid_q;
  assign vld = valid_q;
  assign ready_o = !valid_q || acc;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      valid_q <= 1'b0;
      out_q <= '0;
    end else if (flush_i) valid_q <= 1'b0;
    else if (ready_o) begin
      valid_q <= tk;
      if (tk) out_q <= in_ent;
    end
`endif
  always_comb cnt_d = (vld && !acc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;
  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  a;
    logic [1:0]  c;
  } ent_t;
  logic clk = 0, rst_i = 1, valid_i = 0, ready_i = 0, stall_i = 0, flush_i = 0;
  logic [31:0] data0_i = 0, data1_i = 0;
  logic [4:0] rd_addr_i = 0;
  logic [1:0] ctrl_i = 0;
  logic ready_o, valid_o;
  logic [31:0] data0_o, data1_o;
  logic [4:0] rd_addr_o;
  logic [1:0] ctrl_o;
  logic [15:0] stall_cnt_o;
  int total = 0, bad = 0;
  ent_t q[$];
  logic [15:0] cnt = 0;
  always #5 clk = ~clk;
  pipe_stage_reg dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data0_i(data0_i), .data1_i(data1_i), .rd_addr_i(rd_addr_i), .ctrl_i(ctrl_i),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .data0_o(data0_o), .data1_o(data1_o), .rd_addr_o(rd_addr_o), .ctrl_o(ctrl_o),
    .stall_cnt_o(stall_cnt_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  function automatic ent_t mk(input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] a, input logic [1:0] c);
    ent_t e;
    e.d0 = d0; e.d1 = d1; e.a = a; e.c = c;
    return e;
  endfunction
  function automatic ent_t rnd();
    return mk($urandom, $urandom, 5'($urandom), 2'($urandom));
  endfunction
  task automatic check_out(input bit r);
    chk("valid", valid_o, (q.size() > 0));
    chk("ready", ready_o, r);
    chk("stall_cnt", stall_cnt_o, cnt);
    if (q.size() > 0) begin
      chk("data0", data0_o, q[0].d0);
      chk("data1", data1_o, q[0].d1);
      chk("rd_addr", rd_addr_o, q[0].a);
      chk("ctrl", ctrl_o, q[0].c);
    end else chk("ctrl_bubble", ctrl_o, 2'b00);
  endtask
  task automatic cyc(input bit v, input ent_t e, input bit rdy, input bit st, input bit fl, input bit chkf);
    bit r, a, t;
    @(negedge clk);
    valid_i = v; {data0_i, data1_i, rd_addr_i, ctrl_i} = e;
    ready_i = rdy; stall_i = st; flush_i = fl;
    #1;
    a = (q.size() > 0) && rdy && !st;
`ifdef PIPE_STAGE_REG_SKID_EN
    r = q.size() < 2;
`else
    r = (q.size() == 0) || a;
`endif
    t = v && r;
    if (chkf) check_out(r);
    @(posedge clk);
    if (q.size() > 0 && !a && cnt != 16'hFFFF) cnt = cnt + 16'd1;
    if (fl) q.delete();
    else begin
      if (a) void'(q.pop_front());
      if (t) q.push_back(e);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_i = 1; valid_i = 0; flush_i = 0; stall_i = 0;
    #1;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ctrl", ctrl_o, 2'b00);
    chk("rst_cnt", stall_cnt_o, 16'h0);
    chk("rst_data0", data0_o, 32'h0);
    chk("rst_data1", data1_o, 32'h0);
    chk("rst_addr", rd_addr_o, 5'h0);
    chk("rst_ready", ready_o, 1'b1);
    q.delete(); cnt = 0;
    @(negedge clk);
    rst_i = 0;
  endtask
  initial begin
    ent_t z, a, b;
    z = mk(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, mk(32'h10 + i, ~(32'h10 + i), 5'(i), 2'b01), 1, 0, 0, 1);
      if (i == 0) begin
        #1;
        chk("stream_lat1", data0_o, 32'h10);
      end
    end
    repeat (3) cyc(0, z, 1, 0, 0, 1);
    cyc(1, mk(32'hDEAD_BEEF, 1, 3, 2'b11), 0, 0, 0, 1);
    #1;
    chk("pre_rst_valid", valid_o, 1'b1);
    do_reset();
    cyc(1, mk(32'hAAAA_5555, 32'h5555_AAAA, 7, 2'b01), 1, 0, 0, 1);
    repeat (3) cyc(0, z, 1, 1, 0, 1);
    #1;
    chk("stall_cnt3", stall_cnt_o, 16'd3);
    chk("stall_hold", data0_o, 32'hAAAA_5555);
    cyc(0, z, 1, 0, 0, 1);
    #1;
    chk("stall_release", valid_o, 1'b0);
    cyc(1, mk(32'h1111, 2, 3, 2'b01), 0, 0, 0, 1);
    cyc(1, mk(32'h2222, 4, 5, 2'b11), 0, 1, 1, 1);
    #1;
    chk("flush_valid", valid_o, 1'b0);
    chk("flush_ctrl", ctrl_o, 2'b00);
    repeat (3) cyc(0, z, 1, 0, 0, 1);
`ifdef PIPE_STAGE_REG_SKID_EN
    do_reset();
    a = mk(32'hA, 32'hA0, 1, 2'b01);
    b = mk(32'hB, 32'hB0, 2, 2'b11);
    cyc(1, a, 0, 0, 0, 1);
    cyc(1, b, 0, 0, 0, 1);
    #1;
    chk("skid_full_ready", ready_o, 1'b0);
    chk("skid_head", data0_o, 32'hA);
    cyc(0, z, 1, 0, 0, 1);
    #1;
    chk("skid_second", data0_o, 32'hB);
    chk("skid_ready_back", ready_o, 1'b1);
    cyc(0, z, 1, 0, 0, 1);
`else
    a = z; b = z;
`endif
    do_reset();
    for (int i = 0; i < 400; i++)
      cyc($urandom % 4 != 0, rnd(), $urandom % 3 != 0, $urandom % 5 == 0, $urandom % 23 == 0, 1);
    do_reset();
    cyc(1, mk(32'h5A5A, 32'hA5A5, 9, 2'b01), 0, 0, 0, 1);
    for (int i = 0; i < 70000; i++)
      cyc(0, z, 0, 0, 0, (i > 65530 && i < 65540) || i == 69999);
    #1;
    chk("saturate", stall_cnt_o, 16'hFFFF);
    chk("sat_hold", data0_o, 32'h5A5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of each data payload field.
REQ-002 Parameter ADDR_W, default 5, width of destination register address.
REQ-003 Parameter CTRL_W, default 2, width of control bundle (bit0 RegWrite, bit1 MemToReg in default use).
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 valid_i  in  1  upstream entry valid.
REQ-007 ready_o  out  1  stage can accept an entry this cycle.
REQ-008 data0_i, data1_i  in  DATA_W  payload (e.g. memory read data, ALU result).
REQ-009 rd_addr_i  in  ADDR_W  destination address; ctrl_i  in  CTRL_W  control bundle.
REQ-010 stall_i  in  1  hold request from hazard unit; flush_i  in  1  kill all held entries.
REQ-011 valid_o  out  1  output entry valid; ready_i  in  1  downstream accepts.
REQ-012 data0_o, data1_o  out  DATA_W; rd_addr_o  out  ADDR_W; ctrl_o  out  CTRL_W  held entry.
REQ-013 stall_cnt_o  out  16  saturating count of cycles an output entry was held.

Function
REQ-014 Downstream accept acc = valid_o && ready_i && !stall_i; upstream take tk = valid_i && ready_o.
REQ-015 Entry moves output to downstream only on acc; input is captured only on tk; both may occur in one cycle.
REQ-016 ctrl_o SHALL be all-zero whenever valid_o is 0 (no spurious RegWrite from bubbles).
REQ-017 With stall_i high, output register and valid_o hold unchanged; tk still allowed if space exists.
REQ-018 flush_i high at a clock edge: every entry invalidated, valid_o=0 next cycle, tk in same cycle discarded; flush overrides stall.
REQ-019 Payload is latency 1: entry taken at edge N appears on outputs after edge N when output was empty or accepted at N.
REQ-020 Payload fields pass unmodified, bit-exact, in order; no entry duplicated or dropped except by flush.
REQ-021 stall_cnt_o increments by 1 each cycle with valid_o=1 and acc=0; saturates at 0xFFFF; never wraps.
REQ-022 Data registers may hold stale values when invalid; only valid and ctrl gating are mandatory.

Reset
REQ-023 rst_i asserted: immediately valid_o=0, ctrl_o=0, data0_o=data1_o=0, rd_addr_o=0, stall_cnt_o=0, all internal valids 0.
REQ-024 ready_o=1 while rst_i is high and on the first cycle after release.
REQ-025 Reset mid-transfer discards all held entries; no partial capture on the edge where rst_i deasserts.

Configuration
REQ-026 Macro PIPE_STAGE_REG_SKID_EN selects buffering mode.
REQ-027 Defined: two-entry skid buffer, states EMPTY, ONE, TWO; ready_o is a register output (=1 in EMPTY/ONE, 0 in TWO), no combinational path ready_i->ready_o.
REQ-028 Skid transitions: EMPTY-tk->ONE; ONE-tk&!acc->TWO; ONE-acc&!tk->EMPTY; ONE-tk&acc->ONE; TWO-acc->ONE (skid entry moves to output); flush->EMPTY.
REQ-029 Not defined: single entry; ready_o = !valid_o || acc (combinational); no skid storage.
REQ-030 Ordering, flush, reset and counter rules identical in both modes.

Verification
REQ-031 Reset: assert rst_i mid-run with valid_o=1 -> valid_o, ctrl_o, stall_cnt_o read 0 before next edge.
REQ-032 Stream: 8 entries data0_i=0x10..0x17, ready_i=1, stall_i=0 -> same values out in order, one per cycle, 1-cycle latency.
REQ-033 Stall: valid output 0xAAAA_5555, stall_i high 3 cycles -> output held, stall_cnt_o advances 0->3, released next cycle after stall drops.
REQ-034 Flush with concurrent valid_i (ctrl_i=2'b11) -> valid_o=0, ctrl_o=2'b00 next cycle, entry never appears.
REQ-035 Skid build: with macro, ready_i=0 two cycles while sending A,B -> state TWO, ready_o=0; ready_i=1 -> A then B out, ready_o returns 1.
REQ-036 Saturation: hold valid output with ready_i=0 for 70000 cycles -> stall_cnt_o stays 0xFFFF.
